// File: rtl/matrix_result_uart_tx_if.sv
// rtl/matrix_result_uart_tx_if.sv - read bus between the result-dump UART and the 64-entry output memory
interface matrix_result_uart_tx_if #(
    parameter int ADDR_W = 4,
    parameter int MLOC_W = 2,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] mem_addr;
    logic [MLOC_W-1:0] mem_mloc;
    logic              mem_rd;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_addr,
        output mem_mloc,
        output mem_rd,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_mloc,
        input  mem_rd,
        output mem_rdata
    );
endinterface

// File: rtl/matrix_result_uart_tx.sv
// rtl/matrix_result_uart_tx.sv - dumps every Z-matrix result word as uppercase ASCII hex over an 8N1 UART line
module matrix_result_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_W       = 4,
    parameter int MLOC_W       = 2,
    parameter int DATA_W       = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    matrix_result_uart_tx_if.master mem,
    output logic                    tx,
    output logic                    busy,
    output logic                    done
);
    // CLKS_PER_BIT must be at least 2 so the per-bit counter has a real terminal count
    localparam int CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int NIB    = DATA_W / 4;
    localparam int CHAR_W = $clog2(NIB + 2);
    localparam int POS_W  = ADDR_W + MLOC_W;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        SEND_CHAR,
        FINISH
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   clk_cnt;
    logic [3:0]         bit_idx;
    logic [CHAR_W-1:0]  char_idx;
    logic [DATA_W-1:0]  word;
    logic [ADDR_W-1:0]  addr;
    logic [MLOC_W-1:0]  mloc;

    logic               last_mloc;
    logic               last_entry;
    logic               bit_end;
    logic               char_end;
    logic               entry_end;
    logic [3:0]         nib;
    logic [7:0]         hex_char;
    logic [7:0]         cur_char;
    logic [9:0]         frame;

    assign last_mloc  = &mloc;
    assign last_entry = last_mloc && (&addr);
    assign bit_end    = (clk_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign char_end   = bit_end && (bit_idx == 4'd9);
    // mloc 3 carries CR+LF, one character more than the space-terminated slots
    assign entry_end  = char_end &&
                        (char_idx == (last_mloc ? CHAR_W'(NIB + 1) : CHAR_W'(NIB)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The entry-to-entry decision is folded into SEND_CHAR so tx idles only for RD_REQ/RD_WAIT
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:      if (start) state_nxt = RD_REQ;
            RD_REQ:    state_nxt = RD_WAIT;
            RD_WAIT:   state_nxt = SEND_CHAR;
            SEND_CHAR: if (entry_end) state_nxt = last_entry ? FINISH : RD_REQ;
            FINISH:    state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr     <= '0;
            mloc     <= '0;
            clk_cnt  <= '0;
            bit_idx  <= '0;
            char_idx <= '0;
            word     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        addr     <= '0;
                        mloc     <= '0;
                        clk_cnt  <= '0;
                        bit_idx  <= '0;
                        char_idx <= '0;
                    end
                end
                RD_WAIT: word <= mem.mem_rdata;
                SEND_CHAR: begin
                    if (!bit_end) begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end else begin
                        clk_cnt <= '0;
                        if (bit_idx != 4'd9) begin
                            bit_idx <= bit_idx + 4'd1;
                        end else begin
                            bit_idx <= '0;
                            // the word shifts so the digit being sent is always its top nibble
                            if (char_idx < CHAR_W'(NIB)) word <= word << 4;
                            if (entry_end) begin
                                char_idx     <= '0;
                                {addr, mloc} <= {addr, mloc} + POS_W'(1);
                            end else begin
                                char_idx <= char_idx + CHAR_W'(1);
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        nib      = word[DATA_W-1 -: 4];
        hex_char = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
        cur_char = 8'h0A;
        if (char_idx < CHAR_W'(NIB)) begin
            cur_char = hex_char;
        end else if (char_idx == CHAR_W'(NIB)) begin
            cur_char = last_mloc ? 8'h0D : 8'h20;
        end
        frame = {1'b1, cur_char, 1'b0};
        tx    = 1'b1;
        if (state == SEND_CHAR) tx = frame[bit_idx];
        busy  = (state == RD_REQ) || (state == RD_WAIT) || (state == SEND_CHAR);
        done  = (state == FINISH);
    end

    assign mem.mem_rd   = (state == RD_REQ);
    assign mem.mem_addr = addr;
    assign mem.mem_mloc = mloc;
endmodule
